// File: rtl/mem_arbiter_if.sv
// Arbiter-facing bundle: fetch port, load/store port and the byte-wide RAM port.
// slave is the arbiter side; master is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SIZE_W = 3;

    logic              ena;
    logic              in_rollback;

    logic              in_if_req;
    logic [ADDR_W-1:0] in_if_addr;
    logic              out_if_ready;
    logic [DATA_W-1:0] out_if_data;

    logic              in_ls_ena;
    logic              in_ls_iswrite;
    logic [ADDR_W-1:0] in_ls_addr;
    logic [SIZE_W-1:0] in_ls_size;
    logic [DATA_W-1:0] in_ls_data;
    logic              out_ls_ready;
    logic [DATA_W-1:0] out_ls_data;

    logic [BYTE_W-1:0] in_ram_din;
    logic [BYTE_W-1:0] out_ram_dout;
    logic [ADDR_W-1:0] out_ram_addr;
    logic              out_ram_wr;

    modport slave (
        input  ena, in_rollback,
        input  in_if_req, in_if_addr,
        output out_if_ready, out_if_data,
        input  in_ls_ena, in_ls_iswrite, in_ls_addr, in_ls_size, in_ls_data,
        output out_ls_ready, out_ls_data,
        input  in_ram_din,
        output out_ram_dout, out_ram_addr, out_ram_wr
    );

    modport master (
        output ena, in_rollback,
        output in_if_req, in_if_addr,
        input  out_if_ready, out_if_data,
        output in_ls_ena, in_ls_iswrite, in_ls_addr, in_ls_size, in_ls_data,
        input  out_ls_ready, out_ls_data,
        output in_ram_din,
        input  out_ram_dout, out_ram_addr, out_ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Owns the byte-wide single-port RAM; serialises fetch and load/store requests into
// byte accesses, assembling reads little-endian and pulsing a one-cycle ready.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    typedef struct packed {
        logic              iswrite;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] data;
    } ls_req_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              pend_valid_q, pend_valid_d;
    ls_req_t           pend_q, pend_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              ls_ready_q, ls_ready_d;
    logic [DATA_W-1:0] ls_data_q, ls_data_d;

    ls_req_t           incoming;
    ls_req_t           sel;
    logic [LANE_W-1:0] rd_lane;
    logic [LANE_W-1:0] wr_lane;

    // Anything other than 1 or 2 bytes is a word access.
    function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] s);
        case (s)
            SIZE_W'(1): return SIZE_W'(1);
            SIZE_W'(2): return SIZE_W'(2);
            default:    return SIZE_W'(4);
        endcase
    endfunction

    always_comb begin
        incoming.iswrite = bus.in_ls_iswrite;
        incoming.addr    = bus.in_ls_addr;
        incoming.size    = norm_size(bus.in_ls_size);
        incoming.data    = bus.in_ls_data;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        rd_buf_d     = rd_buf_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        ram_addr_d   = ram_addr_q;
        ram_dout_d   = ram_dout_q;
        ram_wr_d     = 1'b0;
        if_ready_d   = 1'b0;
        if_data_d    = if_data_q;
        ls_ready_d   = 1'b0;
        ls_data_d    = ls_data_q;
        sel          = pend_valid_q ? pend_q : incoming;
        rd_lane      = LANE_W'(cnt_q - SIZE_W'(1));
        wr_lane      = LANE_W'(cnt_q + SIZE_W'(1));

        // A pulse while the slot is already full is dropped.
        if (bus.in_ls_ena && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_d       = incoming;
        end
        // Rollback flushes speculative loads but never stores.
        if (bus.in_rollback && !pend_d.iswrite) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.ena && !bus.in_rollback) begin
                    if (pend_valid_q || bus.in_ls_ena) begin
                        pend_valid_d = 1'b0;
                        owner_d      = OWN_LS;
                        size_d       = sel.size;
                        wdata_d      = sel.data;
                        ram_addr_d   = sel.addr;
                        cnt_d        = '0;
                        rd_buf_d     = '0;
                        if (sel.iswrite) begin
                            state_d    = WRITE;
                            ram_dout_d = sel.data[BYTE_W-1:0];
                            ram_wr_d   = 1'b1;
                        end else begin
                            state_d = READ;
                        end
                    end else if (bus.in_if_req) begin
                        owner_d    = OWN_IF;
                        size_d     = SIZE_W'(4);
                        ram_addr_d = bus.in_if_addr;
                        cnt_d      = '0;
                        rd_buf_d   = '0;
                        state_d    = READ;
                    end
                end
            end

            // cnt counts cycles since accept; byte cnt-1 is on in_ram_din now.
            READ: begin
                if (bus.in_rollback) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + SIZE_W'(1);
                    if ((cnt_q + SIZE_W'(1)) < size_q) begin
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                    end
                    if (cnt_q != '0) begin
                        rd_buf_d[BYTE_W*rd_lane +: BYTE_W] = bus.in_ram_din;
                    end
                    if (cnt_q == size_q) begin
                        state_d = IDLE;
                        if (owner_q == OWN_IF) begin
                            if_ready_d = 1'b1;
                            if_data_d  = rd_buf_d;
                        end else begin
                            ls_ready_d = 1'b1;
                            ls_data_d  = rd_buf_d;
                        end
                    end
                end
            end

            WRITE: begin
                cnt_d = cnt_q + SIZE_W'(1);
                if ((cnt_q + SIZE_W'(1)) < size_q) begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_dout_d = wdata_q[BYTE_W*wr_lane +: BYTE_W];
                    ram_wr_d   = 1'b1;
                end else begin
                    ls_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            cnt_q        <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            rd_buf_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            ram_addr_q   <= '0;
            ram_dout_q   <= '0;
            ram_wr_q     <= 1'b0;
            if_ready_q   <= 1'b0;
            if_data_q    <= '0;
            ls_ready_q   <= 1'b0;
            ls_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            rd_buf_q     <= rd_buf_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            ram_addr_q   <= ram_addr_d;
            ram_dout_q   <= ram_dout_d;
            ram_wr_q     <= ram_wr_d;
            if_ready_q   <= if_ready_d;
            if_data_q    <= if_data_d;
            ls_ready_q   <= ls_ready_d;
            ls_data_q    <= ls_data_d;
        end
    end

    assign bus.out_if_ready = if_ready_q;
    assign bus.out_if_data  = if_data_q;
    assign bus.out_ls_ready = ls_ready_q;
    assign bus.out_ls_data  = ls_data_q;
    assign bus.out_ram_addr = ram_addr_q;
    assign bus.out_ram_dout = ram_dout_q;
    assign bus.out_ram_wr   = ram_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic        seen_if, seen_ls, seen_wr;
    logic [31:0] wd;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // RAM: byte addressed in cycle t is returned in cycle t+1.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.out_ram_wr) mem[bus.out_ram_addr[15:0]] <= bus.out_ram_dout;
        bus.in_ram_din <= mem[bus.out_ram_addr[15:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    function automatic logic [31:0] peek32(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    task automatic ls_pulse(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d);
        bus.in_ls_ena = 1'b1; bus.in_ls_iswrite = wr; bus.in_ls_addr = a;
        bus.in_ls_size = sz; bus.in_ls_data = d;
    endtask

    initial begin
        rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.ena = 1'b0; bus.in_rollback = 1'b0; bus.in_if_req = 1'b0; bus.in_if_addr = '0;
        bus.in_ls_ena = 1'b0; bus.in_ls_iswrite = 1'b0; bus.in_ls_addr = '0;
        bus.in_ls_size = '0; bus.in_ls_data = '0;
        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05);
        poke(16'h0102, 8'h10); poke(16'h0103, 8'h00);
        poke(16'h2000, 8'hF0); poke(16'hFFFF, 8'h34); poke(16'h0000, 8'h12);

        check("rst_if_ready", 32'(bus.out_if_ready), 32'd0);
        check("rst_if_data",  bus.out_if_data, 32'd0);
        check("rst_ls_ready", 32'(bus.out_ls_ready), 32'd0);
        check("rst_ls_data",  bus.out_ls_data, 32'd0);
        check("rst_ram_addr", bus.out_ram_addr, 32'd0);
        check("rst_ram_dout", 32'(bus.out_ram_dout), 32'd0);
        check("rst_ram_wr",   32'(bus.out_ram_wr), 32'd0);
        rst = 1'b0; bus.ena = 1'b1;
        step();

        // Plain 4-byte fetch.
        bus.in_if_req = 1'b1; bus.in_if_addr = 32'h100;
        step();
        for (int k = 0; k < 4; k++) begin
            check("fetch_addr", bus.out_ram_addr, 32'h100 + 32'(k));
            check("fetch_early_ready", 32'(bus.out_if_ready), 32'd0);
            step();
        end
        check("fetch_c4_ready", 32'(bus.out_if_ready), 32'd0);
        step();
        check("fetch_c5_ready", 32'(bus.out_if_ready), 32'd1);
        check("fetch_data", bus.out_if_data, 32'h00100513);
        bus.in_if_req = 1'b0;
        step();
        check("fetch_pulse_len", 32'(bus.out_if_ready), 32'd0);
        check("fetch_data_hold", bus.out_if_data, 32'h00100513);

        // Byte load and fetch at the same edge: load wins.
        ls_pulse(1'b0, 32'h2000, 3'd1, 32'd0);
        bus.in_if_req = 1'b1; bus.in_if_addr = 32'h100;
        step();
        bus.in_ls_ena = 1'b0;
        check("prio_addr", bus.out_ram_addr, 32'h2000);
        step();
        check("ldb_c1_ready", 32'(bus.out_ls_ready), 32'd0);
        step();
        check("ldb_ready", 32'(bus.out_ls_ready), 32'd1);
        check("ldb_data", bus.out_ls_data, 32'h000000F0);
        check("ldb_no_if_ready", 32'(bus.out_if_ready), 32'd0);
        step();
        check("prio_fetch_accept", bus.out_ram_addr, 32'h100);
        for (int i = 0; i < 4; i++) step();
        check("prio_fetch_early", 32'(bus.out_if_ready), 32'd0);
        step();
        check("prio_fetch_ready", 32'(bus.out_if_ready), 32'd1);
        check("prio_fetch_data", bus.out_if_data, 32'h00100513);
        bus.in_if_req = 1'b0;
        step();

        // Word store.
        wd = 32'hDEADBEEF;
        ls_pulse(1'b1, 32'h30, 3'd4, wd);
        step();
        bus.in_ls_ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("st_wr", 32'(bus.out_ram_wr), 32'd1);
            check("st_addr", bus.out_ram_addr, 32'h30 + 32'(k));
            check("st_dout", 32'(bus.out_ram_dout), 32'(wd[8*k +: 8]));
            check("st_early_ready", 32'(bus.out_ls_ready), 32'd0);
            step();
        end
        check("st_wr_drop", 32'(bus.out_ram_wr), 32'd0);
        check("st_ready", 32'(bus.out_ls_ready), 32'd1);
        check("st_mem", peek32(16'h0030), 32'hDEADBEEF);
        step();
        check("st_pulse_len", 32'(bus.out_ls_ready), 32'd0);

        // Rollback at edge 2 of a fetch, with a load latched at edge 1.
        bus.in_if_req = 1'b1; bus.in_if_addr = 32'h100;
        step();
        ls_pulse(1'b0, 32'h2000, 3'd1, 32'd0);
        step();
        bus.in_ls_ena = 1'b0; bus.in_rollback = 1'b1;
        step();
        bus.in_rollback = 1'b0; bus.in_if_req = 1'b0;
        seen_if = 1'b0; seen_ls = 1'b0; seen_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_if |= bus.out_if_ready; seen_ls |= bus.out_ls_ready; seen_wr |= bus.out_ram_wr;
            step();
        end
        check("rb_fetch_no_ready", 32'(seen_if), 32'd0);
        check("rb_load_flushed", 32'(seen_ls), 32'd0);
        check("rb_no_wr", 32'(seen_wr), 32'd0);

        // Rollback during a store does not stop it.
        ls_pulse(1'b1, 32'h40, 3'd4, 32'h11223344);
        step();
        bus.in_ls_ena = 1'b0;
        step();
        bus.in_rollback = 1'b1;
        step();
        bus.in_rollback = 1'b0;
        check("rbst_wr", 32'(bus.out_ram_wr), 32'd1);
        check("rbst_addr", bus.out_ram_addr, 32'h42);
        check("rbst_dout", 32'(bus.out_ram_dout), 32'h22);
        step();
        step();
        check("rbst_ready", 32'(bus.out_ls_ready), 32'd1);
        check("rbst_wr_drop", 32'(bus.out_ram_wr), 32'd0);
        check("rbst_mem", peek32(16'h0040), 32'h11223344);
        step();

        // Load queued behind a fetch, then held while ena is low; address wraps.
        bus.in_if_req = 1'b1; bus.in_if_addr = 32'h100;
        step();
        step();
        ls_pulse(1'b0, 32'hFFFFFFFF, 3'd2, 32'd0);
        step();
        bus.in_ls_ena = 1'b0; bus.ena = 1'b0;
        step(); step(); step();
        check("ena_fetch_ready", 32'(bus.out_if_ready), 32'd1);
        check("ena_fetch_data", bus.out_if_data, 32'h00100513);
        bus.in_if_req = 1'b0;
        seen_ls = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_ls |= bus.out_ls_ready;
        end
        check("ena_hold_no_ready", 32'(seen_ls), 32'd0);
        check("ena_hold_addr", bus.out_ram_addr, 32'h103);
        bus.ena = 1'b1;
        step();
        check("wrap_addr0", bus.out_ram_addr, 32'hFFFFFFFF);
        step();
        check("wrap_addr1", bus.out_ram_addr, 32'h00000000);
        step();
        check("wrap_early_ready", 32'(bus.out_ls_ready), 32'd0);
        step();
        check("wrap_ready", 32'(bus.out_ls_ready), 32'd1);
        check("wrap_data", bus.out_ls_data, 32'h00001234);
        step();

        // Illegal size 3 behaves as a word load.
        ls_pulse(1'b0, 32'h100, 3'd3, 32'd0);
        step();
        bus.in_ls_ena = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("sz3_early_ready", 32'(bus.out_ls_ready), 32'd0);
        step();
        check("sz3_ready", 32'(bus.out_ls_ready), 32'd1);
        check("sz3_data", bus.out_ls_data, 32'h00100513);
        step();

        // Reset mid-store with a load waiting in the slot.
        ls_pulse(1'b1, 32'h50, 3'd4, 32'hA5A5A5A5);
        step();
        ls_pulse(1'b0, 32'h2000, 3'd1, 32'd0);
        step();
        bus.in_ls_ena = 1'b0; rst = 1'b1;
        step();
        check("mrst_wr", 32'(bus.out_ram_wr), 32'd0);
        check("mrst_ls_ready", 32'(bus.out_ls_ready), 32'd0);
        check("mrst_addr", bus.out_ram_addr, 32'd0);
        check("mrst_if_data", bus.out_if_data, 32'd0);
        rst = 1'b0;
        seen_ls = 1'b0; seen_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_ls |= bus.out_ls_ready; seen_wr |= bus.out_ram_wr;
        end
        check("mrst_no_ready", 32'(seen_ls), 32'd0);
        check("mrst_no_wr", 32'(seen_wr), 32'd0);
        check("mrst_slot_empty", bus.out_ram_addr, 32'd0);
        bus.in_if_req = 1'b1; bus.in_if_addr = 32'h100;
        step();
        check("post_rst_addr", bus.out_ram_addr, 32'h100);
        for (int i = 0; i < 4; i++) step();
        check("post_rst_early", 32'(bus.out_if_ready), 32'd0);
        step();
        check("post_rst_ready", 32'(bus.out_if_ready), 32'd1);
        check("post_rst_data", bus.out_if_data, 32'h00100513);
        bus.in_if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
